fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter DWIDTH, 16, data word width.
REQ-002 Parameter AWIDTH, 8, FIFO address width; FIFO depth = 2**AWIDTH.
REQ-003 Parameter N_REQ, 4, number of write requesters (2..8).
REQ-004 Parameter BURST_LEN, 4, maximum words per grant (1..16).
REQ-005 clk_i  in  1  single clock; all logic on rising edge.
REQ-006 arst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-007 req_valid_i  in  N_REQ  per-requester word valid.
REQ-008 req_data_i  in  N_REQ*DWIDTH  requester k data at bits [k*DWIDTH +: DWIDTH].
REQ-009 req_ready_o  out  N_REQ  per-requester accept; word transferred when valid && ready.
REQ-010 fifo_usedw_i  in  AWIDTH+1  FIFO fill level, driven by the FIFO's usedw_o.
REQ-011 fifo_wrreq_o  out  1  registered FIFO write strobe.
REQ-012 fifo_data_o  out  DWIDTH  registered FIFO write data.
REQ-013 grant_o  out  N_REQ  one-hot current owner; all zero when idle.
REQ-014 busy_o  out  1  high while state is GRANT.

Function
REQ-015 FSM states IDLE and GRANT only.
REQ-016 IDLE: if any req_valid_i is high, the block SHALL select the first valid requester searching upward from rr_ptr, wrapping modulo N_REQ, load owner, clear beat_cnt, go GRANT; otherwise stay IDLE.
REQ-017 No word is accepted in IDLE; req_ready_o = 0 in IDLE.
REQ-018 space = (fifo_usedw_i + fifo_wrreq_o) < 2**AWIDTH, computed at AWIDTH+2 bits to avoid overflow.
REQ-019 GRANT: req_ready_o[owner] = space; all other ready bits 0; transfer = req_valid_i[owner] && space.
REQ-020 On transfer: fifo_wrreq_o <= 1 and fifo_data_o <= owner's data next cycle (latency 1); otherwise fifo_wrreq_o <= 0 and fifo_data_o holds.
REQ-021 beat_cnt increments on each transfer; width clog2(BURST_LEN)+1.
REQ-022 Release from GRANT to IDLE when transfer occurs with beat_cnt == BURST_LEN-1, or when req_valid_i[owner] is low.
REQ-023 A stall for lack of space with valid high SHALL NOT release the grant.
REQ-024 On release rr_ptr <= (owner+1) mod N_REQ; one idle bubble cycle between grants.
REQ-025 fifo_wrreq_o SHALL never cause a write while the FIFO holds 2**AWIDTH words.
REQ-026 grant_o and busy_o are registered and reflect the current state.

Reset
REQ-027 While arst_n_i = 0: state IDLE, rr_ptr 0, owner 0, beat_cnt 0, fifo_wrreq_o 0, fifo_data_o 0, grant_o 0, busy_o 0, req_ready_o 0.
REQ-028 Reset asserted mid-burst SHALL abort the burst immediately; a word registered but not yet written is discarded.
REQ-029 After deassertion arbitration restarts from requester 0.

Configuration
REQ-030 Macro FIFO_WR_ARB_STATS_EN, when defined, adds output word_cnt_o (N_REQ*16), per-requester 16-bit counters incremented on each transfer by that requester, wrapping at 65535->0, reset to 0.
REQ-031 Without FIFO_WR_ARB_STATS_EN the word_cnt_o port and counters SHALL be absent; all other behaviour identical.

Verification
REQ-032 Reset, then all four requesters valid continuously, FIFO usedw 0 -> grants 0,1,2,3,0 in order, 4 words each, one bubble between bursts.
REQ-033 Only requester 2 valid for 2 cycles then low -> 2 words written, grant released, rr_ptr = 3.
REQ-034 fifo_usedw_i = 255 (AWIDTH=8), requester 1 valid -> exactly one write, then req_ready_o = 0, grant held until usedw drops.
REQ-035 Requesters 0 and 3 valid, rr_ptr = 1 -> requester 3 granted first, then 0.
REQ-036 arst_n_i low during 3rd beat of a burst -> all outputs 0 asynchronously; after release first grant goes to lowest valid index.
REQ-037 With FIFO_WR_ARB_STATS_EN, 65537 words from requester 0 -> word_cnt_o[15:0] = 1.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter merging N_REQ valid/ready write streams into one FIFO write port,
// granting up to BURST_LEN words per owner. Define FIFO_WR_ARB_STATS_EN to add word_cnt_o.
module fifo_wr_arb #(
  parameter int DWIDTH    = 16,
  parameter int AWIDTH    = 8,
  parameter int N_REQ     = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                    clk_i,
  input  logic                    arst_n_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DWIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [AWIDTH:0]         fifo_usedw_i,
  output logic                    fifo_wrreq_o,
  output logic [DWIDTH-1:0]       fifo_data_o,
  output logic [N_REQ-1:0]        grant_o,
  output logic                    busy_o
`ifdef FIFO_WR_ARB_STATS_EN
  , output logic [N_REQ*16-1:0]   word_cnt_o
`endif
);

  // Handshake: a word moves on a rising edge when req_valid_i[k] && req_ready_o[k];
  // valid may not depend on ready, and ready is only ever high for the current owner.

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [AWIDTH+1:0] DEPTH_W   = {2'b01, {AWIDTH{1'b0}}};
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [PTR_W-1:0]  LAST_REQ  = PTR_W'(N_REQ - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;
  logic [CNT_W-1:0] beat_cnt;

  logic [AWIDTH+1:0] fill_sum;
  logic              space;
  logic              owner_valid;
  logic [DWIDTH-1:0] owner_data;
  logic              transfer;
  logic              release_now;
  logic [PTR_W-1:0]  next_ptr;
  logic [PTR_W-1:0]  pick;
  logic              arb_found;
  int                arb_idx;

  // The word already registered for writing counts against free space.
  always_comb begin
    fill_sum    = {1'b0, fifo_usedw_i} + {{(AWIDTH+1){1'b0}}, fifo_wrreq_o};
    space       = (fill_sum < DEPTH_W);
    owner_valid = req_valid_i[owner];
    owner_data  = req_data_i[int'(owner)*DWIDTH +: DWIDTH];
    transfer    = (state == S_GRANT) && owner_valid && space;
    release_now = (state == S_GRANT) &&
                  ((transfer && (beat_cnt == LAST_BEAT)) || !owner_valid);
    next_ptr    = (owner == LAST_REQ) ? '0 : owner + 1'b1;
  end

  always_comb begin
    req_ready_o = '0;
    if (state == S_GRANT) req_ready_o[owner] = space;
  end

  // First valid requester at or above rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    pick      = '0;
    arb_found = 1'b0;
    arb_idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      arb_idx = int'(rr_ptr) + i;
      if (arb_idx >= N_REQ) arb_idx = arb_idx - N_REQ;
      if (!arb_found && req_valid_i[PTR_W'(arb_idx)]) begin
        pick      = PTR_W'(arb_idx);
        arb_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      beat_cnt     <= '0;
      fifo_wrreq_o <= 1'b0;
      fifo_data_o  <= '0;
      grant_o      <= '0;
      busy_o       <= 1'b0;
    end else begin
      fifo_wrreq_o <= transfer;
      if (transfer) fifo_data_o <= owner_data;

      case (state)
        S_IDLE: begin
          if (arb_found) begin
            state    <= S_GRANT;
            owner    <= pick;
            beat_cnt <= '0;
            grant_o  <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
            busy_o   <= 1'b1;
          end
        end
        S_GRANT: begin
          if (transfer) beat_cnt <= beat_cnt + 1'b1;
          // A stall for space keeps the grant; only a finished burst or a dropped valid releases.
          if (release_now) begin
            state   <= S_IDLE;
            rr_ptr  <= next_ptr;
            grant_o <= '0;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          grant_o <= '0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] word_cnt [N_REQ];

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int k = 0; k < N_REQ; k++) word_cnt[k] <= '0;
    end else if (transfer) begin
      word_cnt[owner] <= word_cnt[owner] + 16'd1;
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt_out
    assign word_cnt_o[g*16 +: 16] = word_cnt[g];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: queued sources, a modelled FIFO fill level, and a burst-level
// round-robin reference that predicts the written word stream and grant order.
module tb_fifo_wr_arb;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int NR    = 4;
  localparam int BL    = 4;
  localparam int DEPTH = 256;

  logic             clk = 1'b0;
  logic             arst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic [AW:0]      fifo_usedw;
  logic             fifo_wrreq;
  logic [DW-1:0]    fifo_data;
  logic [NR-1:0]    grant;
  logic             busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [NR*16-1:0] word_cnt;
  int               stat_cnt [NR];
`endif

  always #5 clk = ~clk;

  fifo_wr_arb #(.DWIDTH(DW), .AWIDTH(AW), .N_REQ(NR), .BURST_LEN(BL)) dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .fifo_usedw_i (fifo_usedw),
    .fifo_wrreq_o (fifo_wrreq),
    .fifo_data_o  (fifo_data),
    .grant_o      (grant),
    .busy_o       (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    , .word_cnt_o (word_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] src_mem [NR][32];
  int            src_head [NR];
  int            src_len [NR];
  logic [DW-1:0] exp_q [$];
  int            exp_grant [$];

  int            model_ptr, fill, drain_pct, writes_seen, hs_total, idle_run, run_first;
  bit            drain, first_grant;
  logic [NR-1:0] prev_grant;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic drive_sources();
    for (int k = 0; k < NR; k++) begin
      if (src_head[k] < src_len[k]) begin
        req_valid[k]            = 1'b1;
        req_data[k*DW +: DW]    = src_mem[k][src_head[k]];
      end else begin
        req_valid[k]            = 1'b0;
        req_data[k*DW +: DW]    = '0;
      end
    end
  endtask

  task automatic load_words(input int k, input int n, input bit rnd);
    if (src_head[k] >= src_len[k]) begin
      src_head[k] = 0;
      src_len[k]  = 0;
    end
    for (int i = 0; i < n; i++) begin
      src_mem[k][src_len[k]] = rnd ? DW'($urandom) : DW'((k << 8) | src_len[k]);
      src_len[k]++;
    end
    drive_sources();
  endtask

  function automatic bit sources_empty();
    for (int k = 0; k < NR; k++) if (src_head[k] < src_len[k]) return 1'b0;
    return 1'b1;
  endfunction

  // Burst-level reference: pick first non-empty source from the pointer, take up to BL words.
  task automatic predict();
    int rem [NR];
    int pos [NR];
    int tot, p, k, n;
    bit found;
    tot = 0;
    for (int i = 0; i < NR; i++) begin
      rem[i] = src_len[i] - src_head[i];
      pos[i] = src_head[i];
      tot += rem[i];
    end
    p = model_ptr;
    while (tot > 0) begin
      found = 1'b0;
      k = 0;
      for (int i = 0; i < NR; i++) begin
        if (!found && rem[(p + i) % NR] > 0) begin
          k = (p + i) % NR;
          found = 1'b1;
        end
      end
      n = (rem[k] < BL) ? rem[k] : BL;
      for (int w = 0; w < n; w++) exp_q.push_back(src_mem[k][pos[k] + w]);
      pos[k] += n;
      rem[k] -= n;
      tot    -= n;
      exp_grant.push_back(k);
      p = (k + 1) % NR;
    end
    model_ptr = p;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    for (int k = 0; k < NR; k++) begin
      src_head[k] = 0;
      src_len[k]  = 0;
`ifdef FIFO_WR_ARB_STATS_EN
      stat_cnt[k] = 0;
`endif
    end
    drive_sources();
    fill = 0;
    fifo_usedw = '0;
    exp_q.delete();
    exp_grant.delete();
    model_ptr   = 0;
    drain       = 1'b1;
    drain_pct   = 100;
    prev_grant  = '0;
    first_grant = 1'b1;
    idle_run    = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  // One clock: sample at negedge (scoreboard + grant order), update sources/FIFO after posedge.
  task automatic step();
    logic [NR-1:0] hs;
    logic [NR-1:0] eg;
    logic          wr;
    logic [DW-1:0] e;
    bit            pop_now;
    int            e_idx;
    @(negedge clk);
    hs = req_valid & req_ready;
    wr = fifo_wrreq;
    if (wr) begin
      writes_seen++;
      checks++;
      if (fill >= DEPTH) begin
        errors++;
        $display("FAIL overflow: write issued with usedw=%0d, required usedw < %0d", fill, DEPTH);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: data=%h, required no write", fifo_data);
      end else begin
        e = exp_q.pop_front();
        if (fifo_data !== e) begin
          errors++;
          $display("FAIL write_data: got %h, required %h", fifo_data, e);
        end
      end
    end
    if (grant !== '0 && prev_grant === '0) begin
      checks++;
      if (exp_grant.size() == 0) begin
        errors++;
        $display("FAIL unexpected_grant: grant=%b, required no grant", grant);
      end else begin
        e_idx = exp_grant.pop_front();
        eg = '0;
        eg[e_idx] = 1'b1;
        if (grant !== eg) begin
          errors++;
          $display("FAIL grant_order: grant=%b, required %b", grant, eg);
        end
      end
      if (run_first < 0) begin
        for (int k = 0; k < NR; k++) if (grant[k]) run_first = k;
      end
      if (!first_grant) begin
        checks++;
        if (idle_run != 1) begin
          errors++;
          $display("FAIL bubble: %0d idle cycles between grants, required 1", idle_run);
        end
      end
      first_grant = 1'b0;
    end
    if (grant === '0) idle_run++;
    else idle_run = 0;
    prev_grant = grant;
    pop_now = drain && (fill > 0) && ($urandom_range(0, 99) < drain_pct);
    @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++) begin
      if (hs[k]) begin
        src_head[k]++;
        hs_total++;
`ifdef FIFO_WR_ARB_STATS_EN
        stat_cnt[k]++;
`endif
      end
    end
    fill = fill + (wr ? 1 : 0) - (pop_now ? 1 : 0);
    fifo_usedw = fill[AW:0];
    drive_sources();
  endtask

  task automatic run_until_done(input int max_cyc, input string name);
    bit done;
    done = 1'b0;
    first_grant = 1'b1;
    run_first = -1;
    for (int c = 0; c < max_cyc && !done; c++) begin
      step();
      done = sources_empty() && (exp_q.size() == 0) && !busy && !fifo_wrreq;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: %0d words still expected after %0d cycles, required 0", name, exp_q.size(), max_cyc);
    end
    checks++;
    if (exp_grant.size() != 0) begin
      errors++;
      $display("FAIL %s_grants: %0d predicted grants not seen, required 0", name, exp_grant.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    arst_n    = 1'b0;
    req_valid = '1;
    req_data  = {$urandom, $urandom};
    fifo_usedw = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL rst_ready: got %b, required 0", req_ready); end
    checks++; if (grant !== '0) begin errors++; $display("FAIL rst_grant: got %b, required 0", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    checks++; if (fifo_wrreq !== 1'b0) begin errors++; $display("FAIL rst_wrreq: got %b, required 0", fifo_wrreq); end
    checks++; if (fifo_data !== '0) begin errors++; $display("FAIL rst_data: got %h, required 0", fifo_data); end
    do_reset();
    repeat (3) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b, required 0", busy); end
    checks++; if (grant !== '0) begin errors++; $display("FAIL idle_grant: got %b, required 0", grant); end
    load_words(3, 1, 1'b1);
    predict();
    @(negedge clk);
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL idle_ready: got %b, required 0", req_ready); end
    run_until_done(50, "single");
  endtask

  task automatic test_all_four();
    do_reset();
    for (int k = 0; k < NR; k++) load_words(k, 8, 1'b0);
    predict();
    run_until_done(400, "all_four");
    checks++;
    if (run_first != 0) begin errors++; $display("FAIL all_four_first: got %0d, required 0", run_first); end
  endtask

  task automatic test_release_rr();
    do_reset();
    writes_seen = 0;
    load_words(2, 2, 1'b1);
    predict();
    run_until_done(50, "short_burst");
    checks++; if (writes_seen != 2) begin errors++; $display("FAIL short_writes: got %0d, required 2", writes_seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL short_release: busy=%b, required 0", busy); end
    load_words(0, 3, 1'b1);
    load_words(3, 3, 1'b1);
    predict();
    run_until_done(100, "after_short");
    checks++; if (run_first != 3) begin errors++; $display("FAIL rr_after_2: first grant %0d, required 3", run_first); end
    do_reset();
    load_words(0, 1, 1'b1);
    predict();
    run_until_done(50, "prime_rr1");
    load_words(0, 2, 1'b1);
    load_words(3, 2, 1'b1);
    predict();
    run_until_done(100, "rr1");
    checks++; if (run_first != 3) begin errors++; $display("FAIL rr1_first: first grant %0d, required 3", run_first); end
  endtask

  task automatic test_full();
    do_reset();
    fill = 255;
    fifo_usedw = 9'd255;
    drain = 1'b0;
    writes_seen = 0;
    load_words(1, 3, 1'b1);
    predict();
    first_grant = 1'b1;
    run_first = -1;
    repeat (12) step();
    checks++; if (writes_seen != 1) begin errors++; $display("FAIL full_writes: got %0d, required 1", writes_seen); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL full_ready: got %b, required 0", req_ready); end
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL full_grant_held: got %b, required 0010", grant); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %b, required 1", busy); end
    drain = 1'b1;
    drain_pct = 100;
    run_until_done(200, "full_drain");
    checks++; if (writes_seen != 3) begin errors++; $display("FAIL full_total: got %0d, required 3", writes_seen); end
  endtask

  task automatic test_reset_mid_burst();
    bit reached;
    do_reset();
    hs_total = 0;
    load_words(2, 8, 1'b1);
    predict();
    first_grant = 1'b1;
    run_first = -1;
    reached = 1'b0;
    for (int c = 0; c < 60 && !reached; c++) begin
      step();
      reached = (hs_total == 6);
    end
    checks++;
    if (!reached) begin errors++; $display("FAIL mid_reach: %0d handshakes, required 6", hs_total); end
    #2;
    arst_n = 1'b0;
    #1;
    checks++; if (fifo_wrreq !== 1'b0) begin errors++; $display("FAIL mid_wrreq: got %b, required 0", fifo_wrreq); end
    checks++; if (fifo_data !== '0) begin errors++; $display("FAIL mid_data: got %h, required 0", fifo_data); end
    checks++; if (grant !== '0) begin errors++; $display("FAIL mid_grant: got %b, required 0", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b, required 0", busy); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL mid_ready: got %b, required 0", req_ready); end
    do_reset();
    load_words(1, 2, 1'b1);
    load_words(3, 2, 1'b1);
    predict();
    run_until_done(100, "post_reset");
    checks++; if (run_first != 1) begin errors++; $display("FAIL post_reset_first: got %0d, required 1", run_first); end
  endtask

  task automatic test_random();
    do_reset();
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < NR; k++) load_words(k, $urandom_range(0, 12), 1'b1);
      fill = (r % 2 == 1) ? $urandom_range(240, 256) : $urandom_range(0, 100);
      fifo_usedw = fill[AW:0];
      drain_pct = $urandom_range(20, 100);
      predict();
      run_until_done(3000, "random");
    end
`ifdef FIFO_WR_ARB_STATS_EN
    for (int k = 0; k < NR; k++) begin
      checks++;
      if (word_cnt[k*16 +: 16] !== stat_cnt[k][15:0]) begin
        errors++;
        $display("FAIL word_cnt_%0d: got %0d, required %0d", k, word_cnt[k*16 +: 16], stat_cnt[k][15:0]);
      end
    end
`endif
  endtask

  initial begin
    arst_n     = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    fifo_usedw = '0;
    fill       = 0;
    drain      = 1'b1;
    drain_pct  = 100;
    writes_seen = 0;
    hs_total   = 0;
    run_first  = -1;
    for (int k = 0; k < NR; k++) begin
      src_head[k] = 0;
      src_len[k]  = 0;
    end
    test_reset();
    test_all_four();
    test_release_rr();
    test_full();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
